// File: rtl/decode_pipe_if.sv
// Group-in / decoded-head-out bundle for decode_pipe. The slave modport is the
// decoder's view; the master modport is the view of whatever drives and consumes it.
interface decode_pipe_if #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2,
  parameter int PC_W  = 12
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_lane_valid;
  logic [32*WIDTH-1:0]   in_instr;
  logic [PC_W*WIDTH-1:0] in_pc;
  logic                  flush;

  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_lane_valid;
  logic [32*WIDTH-1:0]   out_instr;
  logic [PC_W*WIDTH-1:0] out_pc;
  logic [7*WIDTH-1:0]    out_ctrl;
  logic [3*WIDTH-1:0]    out_alu;
  logic [32*WIDTH-1:0]   out_imm;
  logic [WIDTH-1:0]      out_illegal;
  logic [OCC_W-1:0]      occupancy;

  modport master (
    output in_valid, in_lane_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_lane_valid, out_instr, out_pc,
           out_ctrl, out_alu, out_imm, out_illegal, occupancy
  );

  modport slave (
    input  in_valid, in_lane_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_lane_valid, out_instr, out_pc,
           out_ctrl, out_alu, out_imm, out_illegal, occupancy
  );
endinterface

// File: rtl/decode_pipe.sv
// Multi-lane instruction decoder feeding a small FIFO of decoded groups.
// Decode happens on the incoming group; outputs come only from the queue head.
module decode_pipe #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2,
  parameter int PC_W  = 12
) (
  input logic          clk,
  input logic          rst_n,
  decode_pipe_if.slave bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef struct packed {
    logic [6:0]  ctrl;
    logic [2:0]  alu;
    logic [31:0] imm;
    logic        illegal;
  } dec_t;

  typedef struct packed {
    logic [WIDTH-1:0]      lane_valid;
    logic [32*WIDTH-1:0]   instr;
    logic [PC_W*WIDTH-1:0] pc;
    logic [7*WIDTH-1:0]    ctrl;
    logic [3*WIDTH-1:0]    alu;
    logic [32*WIDTH-1:0]   imm;
    logic [WIDTH-1:0]      illegal;
  } entry_t;

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t       d;
    logic [2:0] f3;
    d  = '0;
    f3 = instr[14:12];
    case (instr[6:0])
      OP_R: begin
        d.ctrl = 7'b1000000;
        case (f3)
          3'b000:  d.alu = 3'b000;
          3'b100:  d.alu = 3'b011;
          3'b101:  d.alu = 3'b010;
          default: d.illegal = 1'b1;
        endcase
      end
      OP_I: begin
        d.ctrl = 7'b1100000;
        d.imm  = {{20{instr[31]}}, instr[31:20]};
        case (f3)
          3'b000:  d.alu = 3'b000;
          3'b101:  d.alu = 3'b010;
          3'b110:  d.alu = 3'b100;
          3'b111:  d.alu = 3'b101;
          default: d.illegal = 1'b1;
        endcase
      end
      OP_LUI: begin
        d.ctrl = 7'b1100000;
        d.alu  = 3'b001;
        d.imm  = {{12{instr[31]}}, instr[31:12]};
      end
      OP_LOAD: begin
        d.imm = {{20{instr[31]}}, instr[31:20]};
        case (f3)
          3'b000:  d.ctrl = 7'b1101011;
          3'b010:  d.ctrl = 7'b1101010;
          default: d.illegal = 1'b1;
        endcase
      end
      OP_STORE: begin
        d.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        case (f3)
          3'b000:  d.ctrl = 7'b0100101;
          3'b010:  d.ctrl = 7'b0100100;
          default: d.illegal = 1'b1;
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    // Illegal encodings report only the flag; partial decode fields are cleared.
    if (d.illegal) begin
      d         = '0;
      d.illegal = 1'b1;
    end
    return d;
  endfunction

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  entry_t new_entry;
  entry_t head;
  logic   in_ready;
  logic   push;
  logic   pop;

  // rst_n appears here so upstream sees not-ready for the whole reset window.
  assign in_ready = rst_n && (occ_q < OCC_W'(DEPTH)) && !bus.flush;
  assign push     = bus.in_valid && in_ready && (|bus.in_lane_valid);
  assign pop      = (occ_q != '0) && bus.out_ready;

  always_comb begin
    dec_t dec;
    dec                  = '0;
    new_entry            = '0;
    new_entry.lane_valid = bus.in_lane_valid;
    new_entry.instr      = bus.in_instr;
    new_entry.pc         = bus.in_pc;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      dec = decode(bus.in_instr[32*i +: 32]);
      if (bus.in_lane_valid[i]) begin
        new_entry.ctrl[7*i +: 7]   = dec.ctrl;
        new_entry.alu[3*i +: 3]    = dec.alu;
        new_entry.imm[32*i +: 32]  = dec.imm;
        new_entry.illegal[i]       = dec.illegal;
      end
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = new_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // Storage is cleared by reset so head fields read zero until the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign head               = mem_q[rd_ptr_q];
  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = (occ_q != '0);
  assign bus.out_lane_valid = head.lane_valid;
  assign bus.out_instr      = head.instr;
  assign bus.out_pc         = head.pc;
  assign bus.out_ctrl       = head.ctrl;
  assign bus.out_alu        = head.alu;
  assign bus.out_imm        = head.imm;
  assign bus.out_illegal    = head.illegal;
  assign bus.occupancy      = occ_q;

endmodule
